// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Build option: define IMEM_GNT_STALL_EN to enable pseudo-random grant stalls.
package imem_pkg;

  // One response token travelling down the latency delay line.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_rsp_t;

  // Data returned with an access fault.
  localparam logic [31:0] IMEM_ERR_DATA = 32'h0;

  // Fibonacci LFSR taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
  localparam logic [7:0] IMEM_LFSR_TAPS = 8'hB8;

  // Shift left, feedback is the XOR of the tapped bits.
  function automatic logic [7:0] imem_lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & IMEM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-latency delay line for response tokens.
// A token enters at the accepting edge and leaves LATENCY edges later.
// err/data of a stage only change when a valid token moves in, so the
// last stage holds the most recent response while valid is low.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_err,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic        out_err,
  output logic [31:0] out_data
);

  imem_rsp_t stage [LATENCY];

  // Shift tokens one stage per clock; clear everything on reset so no
  // response in flight survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_valid;
      if (in_valid) begin
        stage[0].err  <= in_err;
        stage[0].data <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage[i].valid <= stage[i-1].valid;
        if (stage[i-1].valid) begin
          stage[i].err  <= stage[i-1].err;
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign out_valid = stage[LATENCY-1].valid;
  assign out_err   = stage[LATENCY-1].err;
  assign out_data  = stage[LATENCY-1].data;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: target side of the fetch req/gnt/rvalid bus.
// Holds the word RAM, address decode, outstanding counter and, when
// IMEM_GNT_STALL_EN is defined, an LFSR that injects grant stalls.
//
// Handshake: a request is accepted on a rising edge where instr_req_i and
// instr_gnt_o are both high. instr_gnt_o comes from registered state only
// and may be high with no request. Every accepted request gets exactly one
// instr_rvalid_o pulse LATENCY cycles later, in acceptance order; there is
// no backpressure on responses. instr_rdata_o/instr_err_o are meaningful
// only while instr_rvalid_o is high.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = "",
  parameter logic [7:0]  STALL_SEED      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_req_i,
  output logic                     instr_gnt_o,
  input  logic [31:0]              instr_addr_i,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  output logic                     instr_rvalid_o,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_wdata_i
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          accept;
  logic          room;
  logic          stall;
  logic [CW-1:0] cnt;
  logic          rsp_err;
  logic [31:0]   rsp_data;

  // Decode: offset from the base wraps at 32 bits, so addresses below the
  // base land far out of range.
  assign off      = instr_addr_i - BASE_ADDR;
  assign in_range = (off < SPAN);
  assign idx      = off[AW+1:2];

  // Grant from registered state only: room for another outstanding request.
  assign room        = (int'(cnt) < MAX_OUTSTANDING);
  assign instr_gnt_o = room & ~stall & ~rst;
  assign accept      = instr_req_i & instr_gnt_o;

  // Fault responses never touch the RAM.
  assign rsp_err  = ~in_range;
  assign rsp_data = in_range ? mem[idx] : IMEM_ERR_DATA;

  // Load-port write; the fetch read of the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Outstanding count: +1 on accept, -1 on response, unchanged on both.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({accept, instr_rvalid_o})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef IMEM_GNT_STALL_EN
  logic [7:0] lfsr;

  // Free-running stall generator, restarted from the seed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= STALL_SEED;
    end else begin
      lfsr <= imem_lfsr_next(lfsr);
    end
  end

  assign stall = lfsr[0];
`else
  logic [7:0] unused_seed;

  assign unused_seed = STALL_SEED;
  assign stall       = 1'b0;
`endif

  imem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_err    (rsp_err),
    .in_data   (rsp_data),
    .out_valid (instr_rvalid_o),
    .out_err   (instr_err_o),
    .out_data  (instr_rdata_o)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder. Three instances share one stimulus stream:
//   0: base 0,      latency 1
//   1: base 0x1000, latency 1
//   2: base 0,      latency 3
// All have DEPTH 16 and MAX_OUTSTANDING 2.
module tb_imem_responder;

  localparam int          NDUT   = 3;
  localparam logic [31:0] BASE_B = 32'h1000;
  localparam int          LAT_C  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [31:0] load_wdata;

  logic        gnt    [NDUT];
  logic        rvalid [NDUT];
  logic        err    [NDUT];
  logic [31:0] rdata  [NDUT];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference RAM image and scoreboard: entry = {due_cycle, err, data}.
  logic [31:0] m [16];
  logic [64:0] exp_q [NDUT][$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference RAM: writes land at the edge, after any same-edge read.
  always @(posedge clk) begin
    if (load_we && !rst) m[load_addr] <= load_wdata;
  end

`ifdef IMEM_GNT_STALL_EN
  logic [7:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  // ---------------- DUTs ----------------
  imem_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_gnt_o(gnt[0]), .instr_addr_i(addr),
    .instr_rdata_o(rdata[0]), .instr_err_o(err[0]), .instr_rvalid_o(rvalid[0]),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));

  imem_responder #(.DEPTH(16), .BASE_ADDR(BASE_B), .LATENCY(1), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_gnt_o(gnt[1]), .instr_addr_i(addr),
    .instr_rdata_o(rdata[1]), .instr_err_o(err[1]), .instr_rvalid_o(rvalid[1]),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));

  imem_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .LATENCY(LAT_C), .MAX_OUTSTANDING(2)) u_c (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_gnt_o(gnt[2]), .instr_addr_i(addr),
    .instr_rdata_o(rdata[2]), .instr_err_o(err[2]), .instr_rvalid_o(rvalid[2]),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? BASE_B : 32'h0;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 2) ? LAT_C : 1;
  endfunction

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // At each falling edge: compare any response, flag a missing one, then
  // record the request the next rising edge will accept.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      logic [64:0] e;
      logic [31:0] off;
      if (rvalid[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("spurious_rvalid_dut%0d", k), 64'(rvalid[k]), 64'd0);
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("rsp_cycle_dut%0d", k), 64'(cyc), 64'(e[64:33]));
          chk($sformatf("rsp_err_dut%0d", k), 64'(err[k]), 64'(e[32]));
          chk($sformatf("rsp_data_dut%0d", k), 64'(rdata[k]), 64'(e[31:0]));
        end
      end else if (exp_q[k].size() != 0 && int'(exp_q[k][0][64:33]) <= cyc) begin
        chk($sformatf("missing_rvalid_dut%0d", k), 64'(rvalid[k]), 64'd1);
        void'(exp_q[k].pop_front());
      end
      if (rst) begin
        exp_q[k].delete();
      end else if (req && gnt[k]) begin
        off = addr - base_of(k);
        if (off >= 32'd64) e = {32'(cyc + lat_of(k)), 1'b1, 32'h0};
        else               e = {32'(cyc + lat_of(k)), 1'b0, m[off[5:2]]};
        exp_q[k].push_back(e);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] pat3;
    pat3 = 5'b10011;
    rst = 1'b1; req = 1'b0; addr = '0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_gnt_dut%0d", k), 64'(gnt[k]), 64'd0);
      chk($sformatf("rst_rvalid_dut%0d", k), 64'(rvalid[k]), 64'd0);
      chk($sformatf("rst_rdata_dut%0d", k), 64'(rdata[k]), 64'd0);
      chk($sformatf("rst_err_dut%0d", k), 64'(err[k]), 64'd0);
    end
    tick();
    rst = 1'b0;

    // Program image; word 5 starts as zero.
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 4'(i);
      load_wdata = (i == 5) ? 32'h0 : $urandom;
      tick();
    end
    load_we = 1'b0;
    tick();

`ifdef IMEM_GNT_STALL_EN
    // Grant pattern follows the LFSR; latency 1 never fills the window.
    req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 32'(i * 4);
      @(negedge clk);
      chk($sformatf("t6_gnt_%0d", i), 64'(gnt[0]), 64'(~lfsr_m[0]));
      tick();
    end
    req = 1'b0;
    repeat (8) tick();
`else
    // Back-to-back fetches at full rate.
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      @(negedge clk);
      chk($sformatf("t1_gnt_%0d", i), 64'(gnt[0]), 64'd1);
      tick();
    end
    req = 1'b0;
    repeat (6) tick();

    // Range edges on the 0x1000-based instance.
    req = 1'b1; addr = 32'h1040;
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("t2_above_rvalid", 64'(rvalid[1]), 64'd1);
    chk("t2_above_err", 64'(err[1]), 64'd1);
    chk("t2_above_rdata", 64'(rdata[1]), 64'd0);
    tick();
    @(negedge clk);
    chk("t2_idle_rvalid", 64'(rvalid[1]), 64'd0);
    chk("t2_hold_err", 64'(err[1]), 64'd1);
    tick();
    req = 1'b1; addr = 32'h0FFC;
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("t2_below_err", 64'(err[1]), 64'd1);
    tick();
    req = 1'b1; addr = 32'h103E;
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("t2_top_err", 64'(err[1]), 64'd0);
    chk("t2_top_rdata", 64'(rdata[1]), 64'(m[15]));
    tick();
    @(negedge clk);
    chk("t2_hold_rdata", 64'(rdata[1]), 64'(m[15]));
    tick();

    // Outstanding limit with latency 3.
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = 32'(i * 4);
      @(negedge clk);
      chk($sformatf("t3_gnt_%0d", i), 64'(gnt[2]), 64'(pat3[i]));
      tick();
    end
    req = 1'b0;
    repeat (6) tick();

    // Same-edge load and fetch of word 5: read-first.
    req = 1'b1; addr = 32'd20;
    load_we = 1'b1; load_addr = 4'd5; load_wdata = 32'hDEADBEEF;
    tick();
    req = 1'b0; load_we = 1'b0;
    @(negedge clk);
    chk("t4_old_rvalid", 64'(rvalid[0]), 64'd1);
    chk("t4_old_rdata", 64'(rdata[0]), 64'h0);
    tick();
    req = 1'b1; addr = 32'd20;
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("t4_new_rdata", 64'(rdata[0]), 64'hDEADBEEF);
    repeat (5) tick();

    // Reset with two requests in flight on the latency-3 instance.
    req = 1'b1; addr = 32'd0;
    tick();
    addr = 32'd4;
    tick();
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_gnt_in_rst_c", 64'(gnt[2]), 64'd0);
    chk("t5_gnt_in_rst_a", 64'(gnt[0]), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("t5_gnt_after_dut%0d", k), 64'(gnt[k]), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("t5_no_rvalid_%0d", i), 64'(rvalid[2]), 64'd0);
    end
    tick();
    req = 1'b1; addr = 32'd8;
    @(negedge clk);
    chk("t5_cnt0_gnt_a", 64'(gnt[2]), 64'd1);
    tick();
    addr = 32'd12;
    @(negedge clk);
    chk("t5_cnt0_gnt_b", 64'(gnt[2]), 64'd1);
    tick();
    req = 1'b0;
    repeat (6) tick();
`endif

    // Random traffic with concurrent loads.
    for (int i = 0; i < 300; i++) begin
      req        = ($urandom_range(0, 3) != 0);
      addr       = ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0) + 32'($urandom_range(0, 79));
      load_we    = ($urandom_range(0, 7) == 0);
      load_addr  = 4'($urandom_range(0, 15));
      load_wdata = $urandom;
      tick();
    end
    req = 1'b0; load_we = 1'b0;
    repeat (8) tick();

    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("end_queue_empty_dut%0d", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
